// File: rtl/vedic_mul_arbiter.sv
// vedic_mul_arbiter: round-robin sharing of one vedic 8x8 multiplier across NREQ requesters, 2-stage pipeline.
// Optional VEDIC_MUL_ARB_STATS_EN adds op_count and stall_count outputs.
module vedic_mul_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_a,
  input  logic [8*NREQ-1:0] req_b,
  output logic [NREQ-1:0]   req_ready,
  output logic              resp_valid,
  output logic [15:0]       resp_prod,
  output logic [IDW-1:0]    resp_id,
  input  logic              resp_ready
`ifdef VEDIC_MUL_ARB_STATS_EN
  ,
  output logic [31:0]       op_count,
  output logic [31:0]       stall_count
`endif
);
  function automatic logic [3:0] vm2(input logic [1:0] a, input logic [1:0] b);
    logic t1, t2, t3, c1;
    t1 = a[1] & b[0];
    t2 = a[0] & b[1];
    t3 = a[1] & b[1];
    c1 = t1 & t2;
    return {t3 & c1, t3 ^ c1, t1 ^ t2, a[0] & b[0]};
  endfunction
  function automatic logic [7:0] vm4(input logic [3:0] a, input logic [3:0] b);
    return {4'b0, vm2(a[1:0], b[1:0])} + {2'b0, vm2(a[3:2], b[1:0]), 2'b0}
         + {2'b0, vm2(a[1:0], b[3:2]), 2'b0} + {vm2(a[3:2], b[3:2]), 4'b0};
  endfunction
  function automatic logic [15:0] vm8(input logic [7:0] a, input logic [7:0] b);
    return {8'b0, vm4(a[3:0], b[3:0])} + {4'b0, vm4(a[7:4], b[3:0]), 4'b0}
         + {4'b0, vm4(a[3:0], b[7:4]), 4'b0} + {vm4(a[7:4], b[7:4]), 8'b0};
  endfunction
  logic [IDW-1:0] ptr, gid, s1_id;
  logic [7:0]     ga, gb, s1_a, s1_b;
  logic           found, s1_valid, stall;
  assign stall = resp_valid & ~resp_ready;
  // lowest valid index overall, then overridden by the lowest at or above ptr (wrap-around search)
  always_comb begin
    found = 1'b0;
    gid = '0;
    ga = '0;
    gb = '0;
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[k]) begin
        found = 1'b1;
        gid = IDW'(k);
        ga = req_a[8*k +: 8];
        gb = req_b[8*k +: 8];
      end
    for (int k = NREQ - 1; k >= 0; k--)
      if (req_valid[k] && IDW'(k) >= ptr) begin
        gid = IDW'(k);
        ga = req_a[8*k +: 8];
        gb = req_b[8*k +: 8];
      end
  end
  assign req_ready = (found & ~stall & ~rst) ? NREQ'(1) << gid : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      s1_valid <= 1'b0;
      s1_a <= '0;
      s1_b <= '0;
      s1_id <= '0;
      resp_valid <= 1'b0;
      resp_prod <= '0;
      resp_id <= '0;
    end else if (!stall) begin
      resp_valid <= s1_valid;
      resp_prod <= vm8(s1_a, s1_b);
      resp_id <= s1_id;
      s1_valid <= found;
      s1_a <= ga;
      s1_b <= gb;
      s1_id <= gid;
      if (found) ptr <= (gid == IDW'(NREQ - 1)) ? '0 : gid + 1'b1;
    end
  end
`ifdef VEDIC_MUL_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      op_count <= '0;
      stall_count <= '0;
    end else begin
      if (resp_valid & resp_ready) op_count <= op_count + 32'd1;
      if (stall && stall_count != '1) stall_count <= stall_count + 32'd1;
    end
  end
`endif
endmodule
